// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: hazard FSM states, register index
// width and the opcode constants shared with the decoder.
package riscv_pkg;

  localparam int REG_ADDR_W = 5;

  localparam logic [6:0] R_TYPE = 7'b0110011;
  localparam logic [6:0] I_TYPE = 7'b0010011;
  localparam logic [6:0] LW     = 7'b0000011;
  localparam logic [6:0] SW     = 7'b0100011;
  localparam logic [6:0] BR     = 7'b1100011;

  typedef enum logic [1:0] {
    RUN         = 2'd0,
    MEM_WAIT    = 2'd1,
    ERR_RECOVER = 2'd2
  } hazard_state_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Data-memory request/ready handshake between the hazard controller
// (master) and the data memory (slave).
interface pipeline_hazard_ctrl_if;
  logic dmem_req;
  logic dmem_ready;

  modport master (
    output dmem_req,
    input  dmem_ready
  );

  modport slave (
    input  dmem_req,
    output dmem_ready
  );
endinterface

// File: rtl/hazard_perf_cnt.sv
// Saturating event counter with synchronous active-low reset.
module hazard_perf_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// 5-stage pipeline hazard/stall controller with dmem wait handling.
// Optional perf counters enabled by HAZARD_PERF_CNT_EN.
module pipeline_hazard_ctrl
  import riscv_pkg::*;
#(
  parameter int REG_ADDR_W  = riscv_pkg::REG_ADDR_W,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  input  logic                  ex_branch_taken,
  input  logic                  mem_mem_read,
  input  logic                  mem_mem_write,
  pipeline_hazard_ctrl_if.master dmem,
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic                  id_ex_write,
  output logic                  ex_mem_write,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic                  mem_wb_bubble,
  output logic                  mem_err,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      flush_count
);

  localparam int TW = $clog2(MEM_TIMEOUT + 1);

  hazard_state_t state;
  logic [TW-1:0] timer;
  logic          access;
  logic          load_use;
  logic          freeze;
  logic          steer;

  assign access   = mem_mem_read | mem_mem_write;
  assign load_use = ex_mem_read && (ex_rd != '0) &&
                    ((ex_rd == id_rs1) || (ex_rd == id_rs2));

  always_comb begin
    dmem.dmem_req = 1'b0;
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    id_ex_write   = 1'b1;
    ex_mem_write  = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    mem_wb_bubble = 1'b0;
    freeze        = 1'b0;
    steer         = 1'b0;
    if (!reset) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      id_ex_write   = 1'b0;
      ex_mem_write  = 1'b0;
      if_id_flush   = 1'b1;
      id_ex_flush   = 1'b1;
      mem_wb_bubble = 1'b1;
    end else begin
      unique case (state)
        RUN: begin
          dmem.dmem_req = access;
          freeze        = access && !dmem.dmem_ready;
          steer         = 1'b1;
        end
        MEM_WAIT: begin
          dmem.dmem_req = 1'b1;
          freeze        = !dmem.dmem_ready;
          steer         = 1'b1;
        end
        default: mem_wb_bubble = 1'b1;
      endcase
      // Freeze outranks branch, which outranks load-use.
      if (steer) begin
        if (freeze) begin
          pc_write      = 1'b0;
          if_id_write   = 1'b0;
          id_ex_write   = 1'b0;
          ex_mem_write  = 1'b0;
          mem_wb_bubble = 1'b1;
        end else if (ex_branch_taken) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (load_use) begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          id_ex_flush = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= RUN;
      timer   <= '0;
      mem_err <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (freeze) begin
            state <= MEM_WAIT;
            timer <= TW'(1);
          end
        end
        MEM_WAIT: begin
          if (dmem.dmem_ready) begin
            state <= RUN;
            timer <= '0;
          end else if (timer == TW'(MEM_TIMEOUT)) begin
            state   <= ERR_RECOVER;
            timer   <= '0;
            mem_err <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          state <= RUN;
          timer <= '0;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  hazard_perf_cnt #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (!pc_write),
    .count (stall_cycles)
  );

  hazard_perf_cnt #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (if_id_flush),
    .count (flush_count)
  );
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed-vector bench for pipeline_hazard_ctrl.
// Control vector order: {req,pc,ifid,idex,exmem,ifl,exfl,bub}.
module tb_pipeline_hazard_ctrl;
  import riscv_pkg::*;

`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam logic [7:0] C_NORM = 8'b0_1111_000;
  localparam logic [7:0] C_RST  = 8'b0_0000_111;
  localparam logic [7:0] C_FRZ  = 8'b1_0000_001;
  localparam logic [7:0] C_LU   = 8'b0_0011_010;
  localparam logic [7:0] C_BR   = 8'b0_1111_110;
  localparam logic [7:0] C_REL  = 8'b1_1111_000;
  localparam logic [7:0] C_RELB = 8'b1_1111_110;
  localparam logic [7:0] C_ERR  = 8'b0_1111_001;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       ex_mem_read, ex_branch_taken;
  logic       mem_mem_read, mem_mem_write;
  logic       pc_write, if_id_write, id_ex_write, ex_mem_write;
  logic       if_id_flush, id_ex_flush, mem_wb_bubble, mem_err;
  logic [31:0] stall_cycles, flush_count;

  int n_vec = 0;
  int n_bad = 0;

  pipeline_hazard_ctrl_if dif();

  pipeline_hazard_ctrl dut (
    .clk             (clk),
    .reset           (reset),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .ex_rd           (ex_rd),
    .ex_mem_read     (ex_mem_read),
    .ex_branch_taken (ex_branch_taken),
    .mem_mem_read    (mem_mem_read),
    .mem_mem_write   (mem_mem_write),
    .dmem            (dif),
    .pc_write        (pc_write),
    .if_id_write     (if_id_write),
    .id_ex_write     (id_ex_write),
    .ex_mem_write    (ex_mem_write),
    .if_id_flush     (if_id_flush),
    .id_ex_flush     (id_ex_flush),
    .mem_wb_bubble   (mem_wb_bubble),
    .mem_err         (mem_err),
    .stall_cycles    (stall_cycles),
    .flush_count     (flush_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc(input string tag, input logic [7:0] ctl,
                     input logic err);
    @(negedge clk);
    chk({tag, ".ctl"}, {24'd0, dif.dmem_req, pc_write, if_id_write,
        id_ex_write, ex_mem_write, if_id_flush, id_ex_flush,
        mem_wb_bubble}, {24'd0, ctl});
    chk({tag, ".err"}, {31'd0, mem_err}, {31'd0, err});
    @(posedge clk);
    #1;
  endtask

  task automatic cnt(input string tag, input int st, input int fl);
    @(negedge clk);
    chk({tag, ".stall"}, stall_cycles, PERF ? st : 0);
    chk({tag, ".flush"}, flush_count, PERF ? fl : 0);
  endtask

  initial begin
    reset = 1'b0;
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    ex_mem_read = 0; ex_branch_taken = 0;
    mem_mem_read = 0; mem_mem_write = 0;
    dif.dmem_ready = 0;

    cyc("rst0", C_RST, 0);
    cyc("rst1", C_RST, 0);
    cnt("rst", 0, 0);
    reset = 1'b1;
    cyc("idle", C_NORM, 0);

    ex_mem_read = 1; ex_rd = 5; id_rs2 = 5;
    cyc("lu_rs2", C_LU, 0);
    ex_mem_read = 0; ex_rd = 0;
    cyc("lu_done", C_NORM, 0);
    ex_mem_read = 1; ex_rd = 0; id_rs1 = 0; id_rs2 = 0;
    cyc("lu_x0", C_NORM, 0);
    ex_rd = 7; id_rs1 = 7; id_rs2 = 3;
    cyc("lu_rs1", C_LU, 0);
    ex_branch_taken = 1;
    cyc("br_lu", C_BR, 0);
    ex_branch_taken = 0; ex_mem_read = 0; ex_rd = 0;
    dif.dmem_ready = 1;
    cyc("rdy_noreq", C_NORM, 0);
    dif.dmem_ready = 0;
    cnt("perf1", 2, 1);

    reset = 0;
    cyc("rst2", C_RST, 0);
    reset = 1;
    mem_mem_read = 1;
    cyc("wait0", C_FRZ, 0);
    cyc("wait1", C_FRZ, 0);
    cyc("wait2", C_FRZ, 0);
    dif.dmem_ready = 1;
    cyc("release", C_REL, 0);
    mem_mem_read = 0; dif.dmem_ready = 0;
    cnt("perf2", 3, 0);
    cyc("post_rel", C_NORM, 0);

    mem_mem_read = 1;
    cyc("bw0", C_FRZ, 0);
    ex_branch_taken = 1;
    cyc("bw1", C_FRZ, 0);
    dif.dmem_ready = 1;
    cyc("bw_rel", C_RELB, 0);
    mem_mem_read = 0; dif.dmem_ready = 0; ex_branch_taken = 0;
    cyc("bw_post", C_NORM, 0);

    mem_mem_write = 1;
    cyc("to_run", C_FRZ, 0);
    for (int i = 0; i < 15; i++) cyc("to_wait", C_FRZ, 0);
    cyc("to_err", C_ERR, 1);
    mem_mem_write = 0;
    cyc("to_run2", C_NORM, 1);
    cyc("to_sticky", C_NORM, 1);

    mem_mem_read = 1;
    cyc("rw0", C_FRZ, 1);
    cyc("rw1", C_FRZ, 1);
    reset = 0;
    cyc("rw_rst", C_RST, 1);
    reset = 1; mem_mem_read = 0;
    cyc("rw_run", C_NORM, 0);
    cnt("rw_cnt", 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Sequences the 5-stage RISC-V pipeline: per-stage register write enables, bubble/flush controls, and the data-memory request handshake.
- Resolves load-use hazards, taken-branch flushes and multi-cycle data-memory accesses.
- Sits beside the main decoder. Consumes ID/EX/MEM stage fields and drives the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.

Parameters:
- REG_ADDR_W, 5, register index width
- MEM_TIMEOUT, 15, max cycles in MEM_WAIT before abort
- CNT_W, 32, performance counter width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- id_rs1, id_rs2  in  REG_ADDR_W  source regs of instruction in ID
- ex_rd  in  REG_ADDR_W  destination reg of instruction in EX
- ex_mem_read  in  1  EX instruction is a load
- ex_branch_taken  in  1  EX branch resolved taken
- mem_mem_read, mem_mem_write  in  1  MEM-stage memory access
- dmem_ready  in  1  data memory completes access this cycle
- dmem_req  out  1  data memory request strobe
- pc_write, if_id_write, id_ex_write, ex_mem_write  out  1  register enables
- if_id_flush, id_ex_flush, mem_wb_bubble  out  1  insert NOP into stage register
- mem_err  out  1  sticky timeout flag
- stall_cycles, flush_count  out  CNT_W  perf counters (0 without macro)

Behaviour:
- States: RUN, MEM_WAIT, ERR_RECOVER. Registered state, timer (width clog2(MEM_TIMEOUT+1)), mem_err. Outputs are combinational from state plus inputs.
- Reset (reset==0 at clk edge):
  - state=RUN, timer=0, mem_err=0, counters=0.
  - While reset is low: all *_write=0, if_id_flush=id_ex_flush=mem_wb_bubble=1, dmem_req=0.
- RUN:
  - dmem_req = mem_mem_read|mem_mem_write.
  - If dmem_req && !dmem_ready: freeze. All *_write=0, mem_wb_bubble=1, no flush. Next state MEM_WAIT, timer=1.
  - Else, priority branch > load-use:
    - Taken branch: all enables=1, if_id_flush=1, id_ex_flush=1.
    - Load-use (ex_mem_read && ex_rd!=0 && (ex_rd==id_rs1 || ex_rd==id_rs2)): pc_write=0, if_id_write=0, id_ex_flush=1, ex_mem_write=1.
    - Otherwise: all enables=1, no flush.
- MEM_WAIT:
  - dmem_req held at 1. Full freeze as above.
  - dmem_ready: release that cycle. Apply RUN branch/load-use logic using the current inputs. Next state RUN, timer=0.
  - Otherwise timer increments. When timer==MEM_TIMEOUT without ready: mem_err<=1, next state ERR_RECOVER.
- ERR_RECOVER (one cycle): dmem_req=0, all enables=1, mem_wb_bubble=1 (faulting access dropped), if_id_flush=id_ex_flush=0. Next state RUN.
- Simultaneous events:
  - Freeze overrides branch and load-use. A branch seen during MEM_WAIT is acted on at the release cycle, because EX is held.
  - dmem_ready with no dmem_req is ignored.
- ex_rd==0 never stalls.
- mem_err clears only on reset.
- Reset mid-MEM_WAIT: abandons the access immediately. dmem_req drops in the same cycle.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- When defined:
  - stall_cycles increments on every cycle with pc_write==0 and reset==1.
  - flush_count increments on every cycle with if_id_flush==1 and reset==1.
  - Both saturate at all-ones.
- When undefined: both outputs tied to 0, no counter flops.

Decomposition:
- Shared package riscv_pkg holds:
  - hazard_state_t enum {RUN, MEM_WAIT, ERR_RECOVER}
  - REG_ADDR_W
  - Opcode constants (R_TYPE, I_TYPE, LW, SW, BR) shared with the decoder
- One sub-module: hazard_perf_cnt, a saturating counter instantiated twice under HAZARD_PERF_CNT_EN.

Test Plan:
- Reset then release with no hazards -> cycle after release: all enables=1, flushes=0, state RUN, mem_err=0.
- ex_mem_read=1, ex_rd=5, id_rs2=5 -> pc_write=0, if_id_write=0, id_ex_flush=1 for exactly 1 cycle. Repeat with ex_rd=0 -> no stall.
- mem_mem_read=1, dmem_ready low 3 cycles then high -> dmem_req=1 and full freeze for 3 cycles, release on 4th. Under macro, stall_cycles=3 after the release.
- ex_branch_taken=1 with a coincident load-use match -> if_id_flush=id_ex_flush=1, pc_write=1 (branch wins).
- mem_mem_write=1, dmem_ready never asserted -> mem_err=1 after 15 wait cycles, one ERR_RECOVER cycle with mem_wb_bubble=1, then RUN.
- Reset asserted during MEM_WAIT -> dmem_req=0 same cycle, state RUN after release, counters=0.
